// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the 24-bit CPU ALU: default data width,
// operation selector codes and the result-selector FSM encoding.
package cpu_alu_pkg;

  // Default data width of the CPU datapath.
  localparam int ALU_WIDTH = 24;

  // Operation selector codes, one per functional-unit result input.
  localparam logic [2:0] SEL_AND  = 3'd0;
  localparam logic [2:0] SEL_OR   = 3'd1;
  localparam logic [2:0] SEL_ADD  = 3'd2;
  localparam logic [2:0] SEL_LESS = 3'd3;
  localparam logic [2:0] SEL_MUL  = 3'd4;
  localparam logic [2:0] SEL_XOR  = 3'd5;

  // Result-selector FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MUL = 2'd1,
    HOLD     = 2'd2
  } sel_state_e;

endpackage : cpu_alu_pkg

// File: rtl/alu_result_select.sv
// Registered result selector at the ALU output. Picks one functional-unit
// result by sel, waits (with a watchdog) for the multi-cycle multiplier,
// and presents the result with zero/error flags behind valid/ready.
module alu_result_select
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH       = ALU_WIDTH,
  parameter int NUM_IN      = 8,          // must be <= 2**SEL_W
  parameter int SEL_W       = 3,
  parameter int MUL_IDX     = int'(SEL_MUL),
  parameter int MUL_TIMEOUT = 15          // must be >= 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] op_data,
  input  logic                    mul_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic                    out_err
);

  // Every encodable selector gets an entry so that indexing by sel is
  // always in range; unmapped entries read as zero.
  localparam int                 NUM_SEL  = 1 << SEL_W;
  localparam logic [SEL_W:0]     NUM_IN_S = (SEL_W + 1)'(NUM_IN);
  localparam logic [SEL_W-1:0]   MUL_SEL  = SEL_W'(MUL_IDX);
  localparam int                 CNT_W    = (MUL_TIMEOUT > 1) ? $clog2(MUL_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

  sel_state_e       state_reg;
  logic [WIDTH-1:0] data_reg;
  logic             zero_reg;
  logic             err_reg;
  logic             valid_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [WIDTH-1:0] slice_arr [NUM_SEL];
  logic [WIDTH-1:0] sel_slice;
  logic [WIDTH-1:0] mul_slice;
  logic             sel_mapped;
  logic             sel_is_mul;
  logic             accept;

  // Unflatten op_data into a selector-indexed table, zero-padding the
  // codes that have no functional unit behind them.
  generate
    for (genvar gi = 0; gi < NUM_SEL; gi++) begin : g_slice
      if (gi < NUM_IN) begin : g_mapped
        assign slice_arr[gi] = op_data[gi*WIDTH +: WIDTH];
      end else begin : g_unmapped
        assign slice_arr[gi] = '0;
      end
    end
  endgenerate

  assign sel_slice  = slice_arr[sel];
  assign mul_slice  = slice_arr[MUL_SEL];
  assign sel_mapped = ({1'b0, sel} < NUM_IN_S);
  assign sel_is_mul = (sel == MUL_SEL);

  // Ready depends only on state and out_ready, never on op_data or sel.
  always_comb begin
    in_ready = (state_reg == IDLE) || ((state_reg == HOLD) && out_ready);
  end

  assign accept = in_valid && in_ready;

  // FSM with registered result, flags and watchdog counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      zero_reg  <= 1'b1;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE, HOLD: begin
          if (accept) begin
            if (!sel_mapped) begin
              data_reg  <= '0;
              zero_reg  <= 1'b1;
              err_reg   <= 1'b1;
              valid_reg <= 1'b1;
              state_reg <= HOLD;
            end else if (sel_is_mul) begin
              valid_reg <= 1'b0;
              cnt_reg   <= '0;
              state_reg <= WAIT_MUL;
            end else begin
              data_reg  <= sel_slice;
              zero_reg  <= (sel_slice == '0);
              err_reg   <= 1'b0;
              valid_reg <= 1'b1;
              state_reg <= HOLD;
            end
          end else if ((state_reg == HOLD) && out_ready) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        WAIT_MUL: begin
          cnt_reg <= cnt_reg + 1'b1;
          // A completion in the last allowed cycle still counts as success.
          if (mul_done) begin
            data_reg  <= mul_slice;
            zero_reg  <= (mul_slice == '0);
            err_reg   <= 1'b0;
            valid_reg <= 1'b1;
            state_reg <= HOLD;
          end else if (cnt_reg == CNT_LAST) begin
            data_reg  <= '0;
            zero_reg  <= 1'b1;
            err_reg   <= 1'b1;
            valid_reg <= 1'b1;
            state_reg <= HOLD;
          end
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_zero  = zero_reg;
  assign out_err   = err_reg;

endmodule : alu_result_select

// File: tb/tb_alu_result_select.sv
// Directed bench for alu_result_select (NUM_IN = 6 so that selectors 6 and
// 7 are unmapped). A transaction-level model predicts every output each
// cycle; literal expectations along the stimulus pin the model.
module tb_alu_result_select;

  localparam int W  = 24;
  localparam int N  = 6;
  localparam int SW = 3;
  localparam int MI = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] sel = '0;
  logic [N*W-1:0] op_data = '0;
  logic          mul_done = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic          out_err;

  int checks = 0;
  int errors = 0;

  alu_result_select #(
    .WIDTH(W), .NUM_IN(N), .SEL_W(SW), .MUL_IDX(MI), .MUL_TIMEOUT(TO)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .op_data(op_data), .mul_done(mul_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int idx, input logic [W-1:0] v);
    op_data[idx*W +: W] = v;
  endtask

  // Transaction-level model: is a result pending, is a multiply
  // outstanding and for how many cycles, and what the result is.
  bit           m_init = 0;
  bit           m_valid = 0;
  bit           m_err = 0;
  bit           m_wait = 0;
  int           m_waited = 0;
  logic [W-1:0] m_data = '0;

  function automatic bit exp_ready();
    return !m_wait && (!m_valid || out_ready);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init  <= 1;
      m_valid <= 0;
      m_err   <= 0;
      m_wait  <= 0;
      m_data  <= '0;
    end else if (m_wait) begin
      m_waited <= m_waited + 1;
      if (mul_done) begin
        m_wait  <= 0;
        m_valid <= 1;
        m_err   <= 0;
        m_data  <= op_data[MI*W +: W];
      end else if (m_waited + 1 == TO) begin
        m_wait  <= 0;
        m_valid <= 1;
        m_err   <= 1;
        m_data  <= '0;
      end
    end else if (in_valid && exp_ready()) begin
      if (int'(sel) == MI) begin
        m_wait   <= 1;
        m_waited <= 0;
        m_valid  <= 0;
      end else if (int'(sel) < N) begin
        m_valid <= 1;
        m_err   <= 0;
        m_data  <= op_data[int'(sel)*W +: W];
      end else begin
        m_valid <= 1;
        m_err   <= 1;
        m_data  <= '0;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 0;
    end
  end

  // Cycle-by-cycle comparison against the model once reset has been seen.
  always @(negedge clk) begin
    if (m_init) begin
      check("m_in_ready",  W'(in_ready),  W'(exp_ready()));
      check("m_out_valid", W'(out_valid), W'(m_valid));
      check("m_out_data",  out_data,      m_data);
      check("m_out_zero",  W'(out_zero),  W'(m_data == '0));
      check("m_out_err",   W'(out_err),   W'(m_err));
      if (out_valid && out_ready)
        $display("txn t=%0t data=%h zero=%b err=%b", $time, out_data, out_zero, out_err);
    end
  end

  initial begin
    // Reset held two cycles with a request pending.
    rst_n = 1'b0; in_valid = 1'b1; sel = 3'd0;
    repeat (2) tick();
    rst_n = 1'b1; in_valid = 1'b0;
    check("rst_valid", W'(out_valid), '0);
    check("rst_data",  out_data, '0);
    check("rst_zero",  W'(out_zero), 24'd1);
    check("rst_err",   W'(out_err), '0);
    check("rst_ready", W'(in_ready), 24'd1);

    // Back-to-back non-multiply operations.
    set_slice(0, 24'h00000F); set_slice(1, 24'h0000F0);
    set_slice(2, 24'h000F00); set_slice(5, 24'h000000);
    out_ready = 1'b1; in_valid = 1'b1;
    sel = 3'd0; tick();
    check("b2b_and", out_data, 24'h00000F); check("b2b_and_z", W'(out_zero), '0);
    check("b2b_rdy0", W'(in_ready), 24'd1);
    sel = 3'd1; tick();
    check("b2b_or", out_data, 24'h0000F0); check("b2b_rdy1", W'(in_ready), 24'd1);
    sel = 3'd2; tick();
    check("b2b_add", out_data, 24'h000F00); check("b2b_rdy2", W'(in_ready), 24'd1);
    sel = 3'd5; tick();
    check("b2b_xor", out_data, 24'h000000); check("b2b_xor_z", W'(out_zero), 24'd1);
    in_valid = 1'b0; tick();
    check("b2b_drain", W'(out_valid), '0);

    // Backpressure: result holds while op_data and sel change.
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd2; set_slice(2, 24'h123456);
    tick();
    check("bp_data", out_data, 24'h123456); check("bp_ready", W'(in_ready), '0);
    for (int i = 0; i < 3; i++) begin
      set_slice(2, W'(24'h111111 * (i + 1))); sel = 3'd1;
      tick();
      check("bp_hold", out_data, 24'h123456); check("bp_hold_rdy", W'(in_ready), '0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    check("bp_release", W'(out_valid), '0);

    // Multiply completing after a short wait.
    in_valid = 1'b1; sel = 3'd4; set_slice(4, 24'h000001);
    tick();
    in_valid = 1'b0;
    check("mul_wait_v", W'(out_valid), '0); check("mul_wait_r", W'(in_ready), '0);
    repeat (2) begin
      tick();
      check("mul_wait_r", W'(in_ready), '0);
    end
    set_slice(4, 24'hABCDEF); mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    check("mul_valid", W'(out_valid), 24'd1); check("mul_data", out_data, 24'hABCDEF);
    check("mul_err", W'(out_err), '0);
    tick();

    // Watchdog timeout with no completion.
    out_ready = 1'b0; in_valid = 1'b1; sel = 3'd4;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      check("to_pending", W'(out_valid), '0);
    end
    tick();
    check("to_valid", W'(out_valid), 24'd1); check("to_data", out_data, '0);
    check("to_err", W'(out_err), 24'd1); check("to_zero", W'(out_zero), 24'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Completion in the last allowed cycle beats the watchdog.
    in_valid = 1'b1; sel = 3'd4;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < TO; i++) tick();
    set_slice(4, 24'h000777); mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    check("edge_valid", W'(out_valid), 24'd1); check("edge_data", out_data, 24'h000777);
    check("edge_err", W'(out_err), '0);
    out_ready = 1'b1; tick();

    // Unmapped selectors give an error result; a mapped one clears it.
    in_valid = 1'b1; sel = 3'd7;
    tick();
    check("unm7_data", out_data, '0); check("unm7_err", W'(out_err), 24'd1);
    check("unm7_zero", W'(out_zero), 24'd1);
    sel = 3'd6;
    tick();
    check("unm6_err", W'(out_err), 24'd1);
    sel = 3'd0;
    tick();
    check("map_err", W'(out_err), '0); check("map_data", out_data, 24'h00000F);
    in_valid = 1'b0; tick();

    // Reset during a multiply wait; the late completion is ignored.
    in_valid = 1'b1; sel = 3'd4;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mrst_ready", W'(in_ready), 24'd1); check("mrst_valid", W'(out_valid), '0);
    check("mrst_data", out_data, '0);
    set_slice(4, 24'h555555); mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    check("late_done", W'(out_valid), '0); check("late_data", out_data, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_result_select
